// File: rtl/pipe_alu_param.sv
// Four-stage register-bank ALU pipeline: operand capture, execute, register writeback, memory store.
// Define PIPE_FORWARD_EN to bypass RAW hazards at operand capture; undefined reads the register bank only.
module pipe_alu_param #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  input  logic          cfg_we,
  input  logic [RW-1:0] cfg_ra,
  input  logic [DW-1:0] cfg_wd,
  input  logic [AW-1:0] mrd_addr,
  output logic [DW-1:0] mrd_data,
  output logic [DW-1:0] z,
  output logic          z_valid
);

  localparam int RDEPTH = 1 << RW;
  localparam int MDEPTH = 1 << AW;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_PASS_A = 4'd3,
    OP_PASS_B = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_NOT_A  = 4'd8,
    OP_NOT_B  = 4'd9,
    OP_SRL    = 4'd10,
    OP_SLL    = 4'd11
  } op_e;

  // S1: captured operands and the instruction fields that travel with them.
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic [3:0]    func;
    logic [AW-1:0] addr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } s1_t;

  // S2: the execute result, which is also the z output.
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] z;
  } s2_t;

  // S3: result waiting for its memory store.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } s3_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;

  logic [DW-1:0] reg_q [RDEPTH];
  logic [DW-1:0] mem_q [MDEPTH];

  logic [DW-1:0] alu_y;
  logic          cfg_wr_en;
  logic          wb_en;
  logic          st_en;

  function automatic logic [DW-1:0] alu(input logic [3:0]    f,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   y;
    prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    case (f)
      OP_ADD:    y = a + b;
      OP_SUB:    y = a - b;
      OP_MUL:    y = prod[DW-1:0];
      OP_PASS_A: y = a;
      OP_PASS_B: y = b;
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_NOT_A:  y = ~a;
      OP_NOT_B:  y = ~b;
      OP_SRL:    y = a >> 1;
      OP_SLL:    y = a << 1;
      default:   y = '0;
    endcase
    return y;
  endfunction

  always_comb begin
    alu_y = alu(s1_q.func, s1_q.a, s1_q.b);
  end

  always_comb begin
    // NOTE: every field gets a default first so no path through this block can infer a latch.
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.rd    = rd;
    s1_d.func  = func;
    s1_d.addr  = addr;
    s1_d.a     = reg_q[rs1];
    s1_d.b     = reg_q[rs2];
`ifdef PIPE_FORWARD_EN
    // Distance 2 is applied first so the younger distance-1 result overrides it.
    if (s2_q.valid && (s2_q.rd == rs1)) s1_d.a = s2_q.z;
    if (s2_q.valid && (s2_q.rd == rs2)) s1_d.b = s2_q.z;
    if (s1_q.valid && (s1_q.rd == rs1)) s1_d.a = alu_y;
    if (s1_q.valid && (s1_q.rd == rs2)) s1_d.b = alu_y;
`endif
  end

  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.rd    = s1_q.rd;
    s2_d.addr  = s1_q.addr;
    // z keeps its last result through bubbles; z_valid marks the fresh one.
    s2_d.z     = s1_q.valid ? alu_y : s2_q.z;
  end

  always_comb begin
    s3_d       = '0;
    s3_d.valid = s2_q.valid;
    s3_d.addr  = s2_q.addr;
    s3_d.data  = s2_q.z;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Valid bits are already cleared while rst is high; cfg writes are blocked explicitly.
  always_comb begin
    cfg_wr_en = cfg_we && !rst;
    wb_en     = s2_q.valid && !rst;
    st_en     = s3_q.valid && !rst;
  end

  // NOTE: storage arrays carry no reset, so their contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (cfg_wr_en) reg_q[cfg_ra] <= cfg_wd;
    // Later assignment wins, so pipeline writeback beats a same-address preload.
    if (wb_en) reg_q[s2_q.rd] <= s2_q.z;
  end

  always_ff @(posedge clk) begin
    if (st_en) mem_q[s3_q.addr] <= s3_q.data;
  end

  always_comb begin
    mrd_data = mem_q[mrd_addr];
    z        = s2_q.z;
    z_valid  = s2_q.valid;
  end

endmodule

// File: tb/tb_pipe_alu_param.sv
// Self-checking bench for pipe_alu_param: ALU vector table, hand-written pipeline corner
// sequences and a randomized run against an in-flight-queue reference model.
module tb_pipe_alu_param;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int AW = 8;

  localparam logic [3:0] F_ADD = 4'd0,  F_SUB = 4'd1,  F_MUL = 4'd2,  F_PA  = 4'd3;
  localparam logic [3:0] F_PB  = 4'd4,  F_AND = 4'd5,  F_OR  = 4'd6,  F_XOR = 4'd7;
  localparam logic [3:0] F_NA  = 4'd8,  F_NB  = 4'd9,  F_SRL = 4'd10, F_SLL = 4'd11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [RW-1:0] rs1, rs2, rd;
  logic [3:0]    func;
  logic [AW-1:0] addr;
  logic          cfg_we;
  logic [RW-1:0] cfg_ra;
  logic [DW-1:0] cfg_wd;
  logic [AW-1:0] mrd_addr;
  logic [DW-1:0] mrd_data;
  logic [DW-1:0] z;
  logic          z_valid;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_alu_param #(.DW(DW), .RW(RW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .func     (func),
    .addr     (addr),
    .cfg_we   (cfg_we),
    .cfg_ra   (cfg_ra),
    .cfg_wd   (cfg_wd),
    .mrd_addr (mrd_addr),
    .mrd_data (mrd_data),
    .z        (z),
    .z_valid  (z_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus a queue of instructions whose results are
  // known at issue and retire to the register bank two edges later, to memory three edges later.
  typedef struct {
    logic [RW-1:0] rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] res;
    int            age;
  } flight_t;

  flight_t       fl[$];
  logic [DW-1:0] m_reg [16];
  logic [DW-1:0] m_mem [256];
  bit            m_known [256];
  logic [DW-1:0] m_z  = '0;
  bit            m_zv = 1'b0;

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] f, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [31:0] aa, bb, r;
    aa = {16'b0, a};
    bb = {16'b0, b};
    case (f)
      4'd0:    r = aa + bb;
      4'd1:    r = aa - bb;
      4'd2:    r = aa * bb;
      4'd3:    r = aa;
      4'd4:    r = bb;
      4'd5:    r = aa & bb;
      4'd6:    r = aa | bb;
      4'd7:    r = aa ^ bb;
      4'd8:    r = ~aa;
      4'd9:    r = ~bb;
      4'd10:   r = aa / 2;
      4'd11:   r = aa * 2;
      default: r = 32'd0;
    endcase
    return r[DW-1:0];
  endfunction

  // With forwarding, an instruction sees the youngest not-yet-retired result for its source.
  function automatic logic [DW-1:0] ref_operand(input logic [RW-1:0] r);
`ifdef PIPE_FORWARD_EN
    for (int i = fl.size() - 1; i >= 0; i--)
      if (fl[i].age <= 1 && fl[i].rd == r) return fl[i].res;
`endif
    return m_reg[r];
  endfunction

  task automatic model_edge();
    flight_t nf;
    bit      have;
    if (rst) begin
      fl.delete();
      m_z  = '0;
      m_zv = 1'b0;
      return;
    end
    have = in_valid;
    if (have) begin
      nf.rd   = rd;
      nf.addr = addr;
      nf.res  = ref_alu(func, ref_operand(rs1), ref_operand(rs2));
      nf.age  = 0;
    end
    if (cfg_we) m_reg[cfg_ra] = cfg_wd;
    m_zv = 1'b0;
    foreach (fl[i]) begin
      fl[i].age++;
      if (fl[i].age == 1) begin
        m_z  = fl[i].res;
        m_zv = 1'b1;
      end
      if (fl[i].age == 2) m_reg[fl[i].rd] = fl[i].res;
      if (fl[i].age == 3) begin
        m_mem[fl[i].addr]   = fl[i].res;
        m_known[fl[i].addr] = 1'b1;
      end
    end
    while (fl.size() > 0 && fl[0].age >= 3) void'(fl.pop_front());
    if (have) fl.push_back(nf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("z_valid", {63'd0, z_valid}, {63'd0, m_zv});
    check("z", {48'd0, z}, {48'd0, m_z});
    if (m_known[mrd_addr]) check("mrd_data", {48'd0, mrd_data}, {48'd0, m_mem[mrd_addr]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input logic [RW-1:0] ra, input logic [DW-1:0] wd);
    cfg_we = 1'b1;
    cfg_ra = ra;
    cfg_wd = wd;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] f, input logic [RW-1:0] a1, input logic [RW-1:0] a2,
                       input logic [RW-1:0] d, input logic [AW-1:0] ad);
    in_valid = 1'b1;
    func     = f;
    rs1      = a1;
    rs2      = a2;
    rd       = d;
    addr     = ad;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic peek_mem(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    mrd_addr = a;
    #1;
    check(name, {48'd0, mrd_data}, {48'd0, exp});
  endtask

  task automatic preload_identity();
    for (int k = 0; k < 16; k++) cfg(RW'(k), DW'(k));
  endtask

  typedef struct {
    logic [3:0]    f;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{F_ADD, 16'h1234, 16'h0F0F, 16'h2143, "vec_add"});
    vecs.push_back('{F_ADD, 16'hFFFF, 16'h0002, 16'h0001, "vec_add_wrap"});
    vecs.push_back('{F_SUB, 16'h0005, 16'h0007, 16'hFFFE, "vec_sub_wrap"});
    vecs.push_back('{F_MUL, 16'h0012, 16'h0034, 16'h03A8, "vec_mul"});
    vecs.push_back('{F_MUL, 16'h0100, 16'h0100, 16'h0000, "vec_mul_wrap"});
    vecs.push_back('{F_PA,  16'hABCD, 16'h1111, 16'hABCD, "vec_pass_a"});
    vecs.push_back('{F_PB,  16'hABCD, 16'h1111, 16'h1111, "vec_pass_b"});
    vecs.push_back('{F_AND, 16'hF0F0, 16'h3C3C, 16'h3030, "vec_and"});
    vecs.push_back('{F_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, "vec_or"});
    vecs.push_back('{F_XOR, 16'hF0F0, 16'h3C3C, 16'hCCCC, "vec_xor"});
    vecs.push_back('{F_NA,  16'h00FF, 16'h1234, 16'hFF00, "vec_not_a"});
    vecs.push_back('{F_NB,  16'h00FF, 16'h1234, 16'hEDCB, "vec_not_b"});
    vecs.push_back('{F_SRL, 16'h8001, 16'h0000, 16'h4000, "vec_srl"});
    vecs.push_back('{F_SLL, 16'h8001, 16'h0000, 16'h0002, "vec_sll"});
    vecs.push_back('{4'd12, 16'h1234, 16'h5678, 16'h0000, "vec_op12"});
    vecs.push_back('{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, "vec_op15"});

    rst      = 1'b1;
    in_valid = 1'b0;
    rs1      = '0;
    rs2      = '0;
    rd       = '0;
    func     = '0;
    addr     = '0;
    cfg_we   = 1'b0;
    cfg_ra   = '0;
    cfg_wd   = '0;
    mrd_addr = '0;

    idle(2);
    check("reset_z", {48'd0, z}, 64'd0);
    check("reset_z_valid", {63'd0, z_valid}, 64'd0);
    rst = 1'b0;

    // Basic ADD flow with identity-preloaded registers.
    preload_identity();
    issue(F_ADD, 4'd3, 4'd5, 4'd10, 8'd125);
    tick();
    check("add_z", {48'd0, z}, 64'd8);
    check("add_z_valid", {63'd0, z_valid}, 64'd1);
    tick();
    check("add_z_valid_pulse", {63'd0, z_valid}, 64'd0);
    tick();
    peek_mem("add_mem125", 8'd125, 16'd8);
    issue(F_PA, 4'd10, 4'd0, 4'd15, 8'd200);
    tick();
    check("add_reg10", {48'd0, z}, 64'd8);

    // Back-to-back MUL then SUB.
    cfg(4'd10, 16'd10);
    issue(F_MUL, 4'd3, 4'd8, 4'd12, 8'd126);
    issue(F_SUB, 4'd10, 4'd5, 4'd14, 8'd128);
    check("b2b_mul_z", {48'd0, z}, 64'd24);
    tick();
    check("b2b_sub_z", {48'd0, z}, 64'd5);
    tick();
    check("b2b_bubble", {63'd0, z_valid}, 64'd0);
    tick();
    peek_mem("b2b_mem126", 8'd126, 16'd24);
    peek_mem("b2b_mem128", 8'd128, 16'd5);

    // Distance-1 RAW dependency.
    issue(F_ADD, 4'd3, 4'd5, 4'd10, 8'd129);
    issue(F_SUB, 4'd10, 4'd5, 4'd14, 8'd130);
    tick();
`ifdef PIPE_FORWARD_EN
    check("raw_dist1", {48'd0, z}, 64'd3);
`else
    check("raw_dist1", {48'd0, z}, 64'd5);
`endif
    idle(3);

    // Shift wrap and subtract underflow.
    cfg(4'd7, 16'h8001);
    issue(F_SLL, 4'd7, 4'd0, 4'd13, 8'd131);
    issue(F_SUB, 4'd3, 4'd5, 4'd13, 8'd132);
    check("sll_wrap", {48'd0, z}, 64'h0002);
    tick();
    check("sub_wrap", {48'd0, z}, 64'hFFFE);
    idle(3);

    // Preload colliding with writeback on the same edge: pipeline result wins.
    issue(F_ADD, 4'd3, 4'd5, 4'd10, 8'd133);
    tick();
    cfg(4'd10, 16'h5555);
    idle(2);
    issue(F_PA, 4'd10, 4'd0, 4'd15, 8'd134);
    tick();
    check("cfg_collision", {48'd0, z}, 64'd8);
    cfg(4'd10, 16'h1234);
    idle(1);
    issue(F_PA, 4'd10, 4'd0, 4'd15, 8'd134);
    tick();
    check("cfg_write", {48'd0, z}, 64'h1234);
    idle(3);

    // ALU vector table.
    foreach (vecs[i]) begin
      cfg(4'd1, vecs[i].a);
      cfg(4'd2, vecs[i].b);
      issue(vecs[i].f, 4'd1, 4'd2, 4'd15, 8'd200);
      tick();
      check(vecs[i].name, {48'd0, z}, {48'd0, vecs[i].exp});
    end
    idle(3);

    // Reset in the middle of three in-flight instructions.
    preload_identity();
    issue(F_ADD, 4'd9, 4'd9, 4'd6, 8'd124);
    issue(F_ADD, 4'd9, 4'd8, 4'd7, 8'd125);
    issue(F_ADD, 4'd9, 4'd4, 4'd8, 8'd126);
    tick();
    check("pre_rst_z", {48'd0, z}, 64'd13);
    rst = 1'b1;
    #1;
    fl.delete();
    m_z  = '0;
    m_zv = 1'b0;
    check("rst_async_z", {48'd0, z}, 64'd0);
    check("rst_async_z_valid", {63'd0, z_valid}, 64'd0);
    cfg(4'd8, 16'h7777);
    idle(2);
    rst = 1'b0;
    idle(1);
    peek_mem("rst_mem124_done", 8'd124, 16'd18);
    peek_mem("rst_mem125_kept", 8'd125, 16'd8);
    peek_mem("rst_mem126_kept", 8'd126, 16'd24);
    issue(F_PA, 4'd8, 4'd0, 4'd15, 8'd200);
    tick();
    check("rst_reg8_kept", {48'd0, z}, 64'd8);
    issue(F_PA, 4'd7, 4'd0, 4'd15, 8'd200);
    tick();
    check("rst_reg7_done", {48'd0, z}, 64'd17);
    idle(3);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      func     = 4'($urandom_range(0, 15));
      rs1      = RW'($urandom_range(0, 15));
      rs2      = RW'($urandom_range(0, 15));
      rd       = RW'($urandom_range(0, 15));
      addr     = AW'($urandom_range(0, 31));
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_ra   = RW'($urandom_range(0, 15));
      cfg_wd   = DW'($urandom);
      mrd_addr = AW'($urandom_range(0, 31));
      tick();
    end
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    for (int a = 0; a < 32; a++) begin
      if (a == 0) idle(4);
      if (m_known[a]) peek_mem("final_mem", AW'(a), m_mem[a]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_alu_param.md
PIPE_ALU_PARAM -- requirements
Module: pipe_alu_param

Interface
REQ-001 Parameter DW, default 16: data width of register bank, ALU and memory words.
REQ-002 Parameter RW, default 4: register address width; register bank depth 2**RW.
REQ-003 Parameter AW, default 8: memory address width; memory depth 2**AW.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  issue strobe; instruction captured on a rising edge when high.
REQ-007 rs1, rs2  input  RW each  source register addresses.
REQ-008 rd  input  RW  destination register address.
REQ-009 func  input  4  operation code.
REQ-010 addr  input  AW  memory store address.
REQ-011 cfg_we, cfg_ra, cfg_wd  input  1/RW/DW  register bank preload write port.
REQ-012 mrd_addr  input  AW; mrd_data  output  DW  combinational memory read port.
REQ-013 z  output  DW  registered ALU result; z_valid  output  1  z holds a newly computed result.

Function
REQ-014 Four stages: S1 operand capture, S2 execute (z), S3 register writeback, S4 memory store.
REQ-015 Edge E with in_valid=1: S1 captures A=reg[rs1], B=reg[rs2], rd, func, addr, valid.
REQ-016 Edge E+1: z <= ALU(A,B), z_valid=1 for exactly one cycle per instruction.
REQ-017 Edge E+2: reg[rd] <= result; Edge E+3: mem[addr] <= result; latency fixed, no stalls.
REQ-018 func: 0 ADD, 1 SUB (A-B), 2 MUL low DW bits, 3 pass A, 4 pass B, 5 AND, 6 OR, 7 XOR, 8 NOT A, 9 NOT B, 10 A>>1 logical, 11 A<<1, 12-15 result 0.
REQ-019 All arithmetic unsigned, wraps modulo 2**DW, no flags.
REQ-020 Back-to-back issue every cycle sustained; in_valid=0 inserts a bubble that performs no register or memory write.
REQ-021 cfg_we writes reg[cfg_ra]<=cfg_wd at the edge; same-edge collision with S3 writeback to same address: S3 wins.
REQ-022 Same rd written by consecutive instructions: youngest value persists.
REQ-023 Same addr stored by consecutive instructions: youngest value persists.
REQ-024 mrd_data reflects memory contents after the most recent edge.

Reset
REQ-025 rst=1: all stage valid bits, z, z_valid clear to 0 immediately, independent of clk.
REQ-026 Register bank and memory not cleared by reset.
REQ-027 Instructions in flight at reset assertion discarded; no register or memory write occurs while rst=1 or from pre-reset instructions.
REQ-028 First instruction after release: captured on first rising edge with rst=0 and in_valid=1.

Configuration
REQ-029 Macro PIPE_FORWARD_EN defined: S1 operand capture bypasses RAW hazards; priority ALU output of instruction in S1 (distance 1), then z of instruction in S2 (distance 2), then register bank.
REQ-030 Macro undefined: operands read from register bank only; distance-1 and distance-2 dependents read stale values; all other behaviour identical.

Verification
REQ-031 Preload reg[k]=k; issue ADD rs1=3 rs2=5 rd=10 addr=125 -> z=8 at E+1, reg[10]=8 at E+2, mem[125]=8 at E+3.
REQ-032 Back-to-back MUL 3,8 rd=12 addr=126; SUB 10,5 rd=14 addr=128 (no prior ADD) -> z=24 then 5, mem[126]=24, mem[128]=5.
REQ-033 ADD 3,5 rd=10 then next cycle SUB 10,5 rd=14 -> with PIPE_FORWARD_EN mem=3; without, z=10-5=5.
REQ-034 SLL func=11 rs1=7 DW=16 preload reg[7]=16'h8001 -> z=16'h0002 (wrap); SUB 3,5 -> z=16'hFFFE.
REQ-035 Issue 3 instructions, assert rst one cycle after third issue -> z=0, z_valid=0 at once; no further reg/mem writes; preloaded values intact.
REQ-036 cfg_we to reg 10 on same edge as S3 writeback to reg 10 -> reg[10] holds pipeline result.
